// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave byte engine: state encoding, sync reset value, byte width.
package i2c_pkg;

    localparam int         BYTE_W   = 8;
    localparam logic [1:0] SYNC_RST = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WRITE,
        S_WR_ACK,
        S_READ,
        S_RD_ACK,
        S_WAIT
    } state_t;

endpackage

// File: rtl/i2c_shift_reg.sv
// Byte shift register: parallel load for transmit, serial MSB-first shift for both directions,
// with a 3-bit bit counter that wraps at each byte boundary.
module i2c_shift_reg
    import i2c_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [BYTE_W-1:0] i_load_data,
    input  logic              i_shift,
    input  logic              i_sin,
    output logic [BYTE_W-1:0] o_data,
    output logic              o_byte_done
);

    logic [BYTE_W-1:0] r_data;
    logic [2:0]        r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_clr) begin
            r_cnt  <= '0;
        end else if (i_load) begin
            r_data <= i_load_data;
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_data <= {r_data[BYTE_W-2:0], i_sin};
            r_cnt  <= r_cnt + 3'd1;
        end
    end

    // Asserted during the shift that completes the byte (the 8th).
    assign o_byte_done = i_shift & (r_cnt == 3'd7);
    assign o_data      = r_data;

endmodule

// File: rtl/i2c_slave_byte_fsm.sv
// I2C slave protocol engine: address match, write byte capture, read byte drive and ACK handling.
// SDA is driven only as an open-drain pull-low enable, updated on the locally detected SCL fall.
module i2c_slave_byte_fsm
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sda_in,
    input  logic              scl_in,
    input  logic              start_det,
    input  logic              stop_det,
    input  logic              scl_rise,
    input  logic [BYTE_W-1:0] tx_data,
    output logic              sda_oe,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_req,
    output logic              addr_hit,
    output logic              rw
);

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_sda_sync, r_scl_sync;
    logic              r_sda_oe, w_sda_oe_nxt;
    logic              r_addr_hit, w_addr_hit_nxt;
    logic              r_rw, w_rw_nxt;
    logic [BYTE_W-1:0] r_rx_data, w_rx_data_nxt;
    logic              r_rx_valid, w_rx_valid_nxt;
    logic              r_tx_pend, w_tx_pend_nxt;
    logic              w_sda_s, w_scl_fall;
    logic              w_clr, w_load, w_shift, w_sin, w_tx_req;
    logic [BYTE_W-1:0] w_sr_data;
    logic              w_byte_done;

    i2c_shift_reg u_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_clr),
        .i_load      (w_load),
        .i_load_data (tx_data),
        .i_shift     (w_shift),
        .i_sin       (w_sin),
        .o_data      (w_sr_data),
        .o_byte_done (w_byte_done)
    );

    assign w_sda_s    = r_sda_sync[1];
    assign w_scl_fall = r_scl_sync[1] & ~r_scl_sync[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sda_sync <= SYNC_RST;
            r_scl_sync <= SYNC_RST;
            r_sda_oe   <= 1'b0;
            r_addr_hit <= 1'b0;
            r_rw       <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_pend  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sda_sync <= {r_sda_sync[0], sda_in};
            r_scl_sync <= {r_scl_sync[0], scl_in};
            r_sda_oe   <= w_sda_oe_nxt;
            r_addr_hit <= w_addr_hit_nxt;
            r_rw       <= w_rw_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_tx_pend  <= w_tx_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sda_oe_nxt   = r_sda_oe;
        w_addr_hit_nxt = r_addr_hit;
        w_rw_nxt       = r_rw;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_tx_pend_nxt  = r_tx_pend;
        w_clr          = 1'b0;
        w_load         = 1'b0;
        w_shift        = 1'b0;
        w_sin          = 1'b0;
        w_tx_req       = 1'b0;

        if (stop_det) begin
            w_state_nxt    = S_IDLE;
            w_sda_oe_nxt   = 1'b0;
            w_addr_hit_nxt = 1'b0;
            w_tx_pend_nxt  = 1'b0;
        end else if (start_det) begin
            w_state_nxt    = S_ADDR;
            w_clr          = 1'b1;
            w_sda_oe_nxt   = 1'b0;
            w_addr_hit_nxt = 1'b0;
            w_tx_pend_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_ADDR: begin
                    if (scl_rise) begin
                        w_shift = 1'b1;
                        w_sin   = w_sda_s;
                        // On the 8th bit the address is already in [6:0] and the R/W bit is on the wire.
                        if (w_byte_done) begin
                            if (w_sr_data[6:0] == SLAVE_ADDR) begin
                                w_rw_nxt    = w_sda_s;
                                w_state_nxt = S_ADDR_ACK;
                            end else begin
                                w_state_nxt = S_WAIT;
                            end
                        end
                    end
                end
                S_ADDR_ACK: begin
                    // addr_hit doubles as the phase flag: clear before the ACK slot, set during it.
                    if (w_scl_fall) begin
                        if (!r_addr_hit) begin
                            w_sda_oe_nxt   = 1'b1;
                            w_addr_hit_nxt = 1'b1;
                        end else if (r_rw) begin
                            w_sda_oe_nxt  = ~w_sr_data[7];
                            w_tx_pend_nxt = 1'b0;
                            w_state_nxt   = S_READ;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = S_WRITE;
                        end
                    end else if (scl_rise && r_addr_hit && r_rw) begin
                        w_tx_req = 1'b1;
                        w_load   = 1'b1;
                    end
                end
                S_WRITE: begin
                    if (scl_rise) begin
                        w_shift = 1'b1;
                        w_sin   = w_sda_s;
                        if (w_byte_done) begin
                            w_rx_data_nxt  = {w_sr_data[6:0], w_sda_s};
                            w_rx_valid_nxt = 1'b1;
                            w_state_nxt    = S_WR_ACK;
                        end
                    end
                end
                S_WR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_sda_oe_nxt = 1'b1;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = S_WRITE;
                        end
                    end
                end
                S_READ: begin
                    if (w_scl_fall) begin
                        // A byte loaded after a master ACK still has its MSB to put on the wire.
                        if (r_tx_pend) begin
                            w_sda_oe_nxt  = ~w_sr_data[7];
                            w_tx_pend_nxt = 1'b0;
                        end else begin
                            w_shift = 1'b1;
                            if (w_byte_done) begin
                                w_sda_oe_nxt = 1'b0;
                                w_state_nxt  = S_RD_ACK;
                            end else begin
                                w_sda_oe_nxt = ~w_sr_data[6];
                            end
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (!w_sda_s) begin
                            w_tx_req      = 1'b1;
                            w_load        = 1'b1;
                            w_tx_pend_nxt = 1'b1;
                            w_state_nxt   = S_READ;
                        end else begin
                            w_state_nxt = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    w_sda_oe_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe   = r_sda_oe;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_req   = w_tx_req;
    assign addr_hit = r_addr_hit;
    assign rw       = r_rw;

endmodule

// File: tb/tb_i2c_slave_byte_fsm.sv
// Bench for i2c_slave_byte_fsm: a bit-level I2C master plus a START/STOP/rise detector model drive the
// slave; expectations come from transaction-level rules (address match, ACK policy, byte contents).
module tb_i2c_slave_byte_fsm;

    localparam logic [6:0] SLAVE = 7'h42;
    localparam int         Q     = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sda_m, scl_m;
    logic       sda_in, scl_in;
    logic       start_det, stop_det, scl_rise, w_fall;
    logic [7:0] tx_data;
    logic       sda_oe, rx_valid, tx_req, addr_hit, rw;
    logic [7:0] rx_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Open-drain bus: the slave can only pull the master's level low.
    assign sda_in = sda_m & ~sda_oe;
    assign scl_in = scl_m;

    logic [1:0] d_sda, d_scl;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_sda <= 2'b11;
            d_scl <= 2'b11;
        end else begin
            d_sda <= {d_sda[0], sda_in};
            d_scl <= {d_scl[0], scl_in};
        end
    end
    assign start_det = d_scl[1] & d_scl[0] & d_sda[1] & ~d_sda[0];
    assign stop_det  = d_scl[1] & d_scl[0] & ~d_sda[1] & d_sda[0];
    assign scl_rise  = ~d_scl[1] & d_scl[0];
    assign w_fall    = d_scl[1] & ~d_scl[0];

    i2c_slave_byte_fsm #(.SLAVE_ADDR(SLAVE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sda_in    (sda_in),
        .scl_in    (scl_in),
        .start_det (start_det),
        .stop_det  (stop_det),
        .scl_rise  (scl_rise),
        .tx_data   (tx_data),
        .sda_oe    (sda_oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_req    (tx_req),
        .addr_hit  (addr_hit),
        .rw        (rw)
    );

    int         cyc = 0, last_rise = -100;
    int         rxv_cnt = 0, txr_cnt = 0;
    logic [7:0] last_rx = 8'h00;
    logic       oe_seen = 1'b0;
    logic       prev_oe = 1'b0, prev_evt = 1'b0, prev_rst = 1'b0;

    // Continuous observation: pulse counts, rx_valid latency, and sda_oe moving only after an SCL fall.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (rx_valid) begin
                rxv_cnt++;
                last_rx = rx_data;
                n_tests++;
                if (cyc !== last_rise + 1) begin
                    n_fail++;
                    $display("FAIL rx_valid_latency: got cycle %0d, required %0d", cyc, last_rise + 1);
                end
            end
            if (tx_req) txr_cnt++;
            if (sda_oe) oe_seen = 1'b1;
            if (scl_rise) last_rise = cyc;
            if (prev_rst && (sda_oe !== prev_oe)) begin
                n_tests++;
                if (!prev_evt) begin
                    n_fail++;
                    $display("FAIL oe_timing: sda_oe changed to %b at cycle %0d without a preceding SCL fall", sda_oe, cyc);
                end
            end
        end
        prev_oe  = sda_oe;
        prev_evt = w_fall | start_det | stop_det;
        prev_rst = rst_n;
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        wait_q();
        sda_m = b;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        s = sda_in;
        wait_q();
        scl_m = 1'b0;
    endtask

    task automatic start_cond();
        sda_m = 1'b1;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        sda_m = 1'b0;
        wait_q();
        scl_m = 1'b0;
    endtask

    task automatic stop_cond();
        sda_m = 1'b0;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        sda_m = 1'b1;
        wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(output logic [7:0] b);
        logic s;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clk_bit(1'b1, s);
            b = {b[6:0], s};
        end
    endtask

    logic [7:0] wbuf[4];
    logic [7:0] rbuf[4];

    task automatic write_xact(input logic [6:0] addr, input int n, input string tag);
        logic ack;
        logic match;
        int   rx0;
        match = (addr == SLAVE);
        rx0   = rxv_cnt;
        start_cond();
        send_byte({addr, 1'b0}, ack);
        n_tests++;
        if (ack !== match) begin
            n_fail++;
            $display("FAIL %s addr_ack: got %b required %b", tag, ack, match);
        end
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], ack);
            n_tests++;
            if (ack !== match) begin
                n_fail++;
                $display("FAIL %s data_ack[%0d]: got %b required %b", tag, i, ack, match);
            end
        end
        n_tests++;
        if (addr_hit !== match) begin
            n_fail++;
            $display("FAIL %s addr_hit_before_stop: got %b required %b", tag, addr_hit, match);
        end
        stop_cond();
        n_tests++;
        if (addr_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL %s addr_hit_after_stop: got %b required 0", tag, addr_hit);
        end
        n_tests++;
        if ((rxv_cnt - rx0) !== (match ? n : 0)) begin
            n_fail++;
            $display("FAIL %s rx_valid_count: got %0d required %0d", tag, rxv_cnt - rx0, match ? n : 0);
        end
        if (match && n > 0) begin
            n_tests++;
            if (last_rx !== wbuf[n-1]) begin
                n_fail++;
                $display("FAIL %s rx_data: got %h required %h", tag, last_rx, wbuf[n-1]);
            end
        end
    endtask

    task automatic read_xact(input logic [6:0] addr, input int n, input string tag);
        logic       ack, s, match;
        logic [7:0] b, exp_b;
        int         tx0;
        match   = (addr == SLAVE);
        tx0     = txr_cnt;
        tx_data = rbuf[0];
        start_cond();
        send_byte({addr, 1'b1}, ack);
        n_tests++;
        if (ack !== match) begin
            n_fail++;
            $display("FAIL %s addr_ack: got %b required %b", tag, ack, match);
        end
        for (int i = 0; i < n; i++) begin
            recv_byte(b);
            exp_b = match ? rbuf[i] : 8'hFF;
            n_tests++;
            if (b !== exp_b) begin
                n_fail++;
                $display("FAIL %s read_byte[%0d]: got %h required %h", tag, i, b, exp_b);
            end
            if (i < n - 1) tx_data = rbuf[i+1];
            clk_bit((i == n - 1) ? 1'b1 : 1'b0, s);
            if (i == n - 1) begin
                n_tests++;
                if (s !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s ack_slot_released: got sda %b required 1", tag, s);
                end
            end
        end
        stop_cond();
        n_tests++;
        if ((txr_cnt - tx0) !== (match ? n : 0)) begin
            n_fail++;
            $display("FAIL %s tx_req_count: got %0d required %0d", tag, txr_cnt - tx0, match ? n : 0);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({sda_oe, rx_data, rx_valid, tx_req, addr_hit, rw} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {sda_oe, rx_data, rx_valid, tx_req, addr_hit, rw});
        end
    endtask

    task automatic test_write();
        logic [6:0] a;
        int         n;
        wbuf[0] = 8'hA5;
        write_xact(SLAVE, 1, "write_a5");
        n_tests++;
        if (rw !== 1'b0) begin
            n_fail++;
            $display("FAIL write_rw: got %b required 0", rw);
        end
        for (int t = 0; t < 6; t++) begin
            a = ($urandom_range(0, 1) == 1) ? SLAVE : 7'($urandom_range(0, 127));
            n = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
            write_xact(a, n, "write_rand");
        end
    endtask

    task automatic test_mismatch();
        oe_seen = 1'b0;
        wbuf[0] = 8'hFF;
        write_xact(7'h43, 1, "mismatch");
        n_tests++;
        if (oe_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL mismatch_sda_oe: got %b required 0", oe_seen);
        end
    endtask

    task automatic test_read();
        rbuf[0] = 8'h3C;
        read_xact(SLAVE, 1, "read_3c");
        n_tests++;
        if (rw !== 1'b1) begin
            n_fail++;
            $display("FAIL read_rw: got %b required 1", rw);
        end
    endtask

    task automatic test_multi_read();
        logic [6:0] a;
        rbuf[0] = 8'h01;
        rbuf[1] = 8'h80;
        read_xact(SLAVE, 2, "read_multi");
        for (int t = 0; t < 5; t++) begin
            a = ($urandom_range(0, 3) != 0) ? SLAVE : 7'($urandom_range(0, 127));
            for (int i = 0; i < 4; i++) rbuf[i] = 8'($urandom);
            read_xact(a, $urandom_range(1, 4), "read_rand");
        end
    endtask

    task automatic test_back_to_back();
        logic       ack, s;
        logic [7:0] b, tv;
        int         rx0, tx0;
        rx0 = rxv_cnt;
        tx0 = txr_cnt;
        tv  = 8'($urandom);
        start_cond();
        send_byte(8'h84, ack);
        send_byte(8'h11, ack);
        tx_data = tv;
        start_cond();
        send_byte(8'h85, ack);
        n_tests++;
        if (ack !== 1'b1) begin
            n_fail++;
            $display("FAIL rstart_addr_ack: got %b required 1", ack);
        end
        n_tests++;
        if (rw !== 1'b1) begin
            n_fail++;
            $display("FAIL rstart_rw: got %b required 1", rw);
        end
        recv_byte(b);
        n_tests++;
        if (b !== tv) begin
            n_fail++;
            $display("FAIL rstart_read_byte: got %h required %h", b, tv);
        end
        clk_bit(1'b1, s);
        n_tests++;
        if (rx_data !== 8'h11 || (rxv_cnt - rx0) !== 1) begin
            n_fail++;
            $display("FAIL rstart_rx: got %h x%0d required 11 x1", rx_data, rxv_cnt - rx0);
        end
        n_tests++;
        if ((txr_cnt - tx0) !== 1) begin
            n_fail++;
            $display("FAIL rstart_tx_req: got %0d required 1", txr_cnt - tx0);
        end
        stop_cond();
    endtask

    task automatic test_reset_mid();
        logic       ack, s;
        logic [7:0] d;
        int         rx0;
        rx0 = rxv_cnt;
        d   = 8'hB6;
        start_cond();
        send_byte(8'h84, ack);
        for (int i = 7; i > 4; i--) clk_bit(d[i], s);
        wait_q();
        sda_m = d[4];
        wait_q();
        scl_m = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (addr_hit !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre_addr_hit: got %b required 1", addr_hit);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({sda_oe, rx_data, rx_valid, tx_req, addr_hit, rw} !== 13'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h required 0", {sda_oe, rx_data, rx_valid, tx_req, addr_hit, rw});
        end
        repeat (3) @(negedge clk);
        scl_m = 1'b0;
        rst_n = 1'b1;
        wait_q();
        stop_cond();
        n_tests++;
        if ((rxv_cnt - rx0) !== 0) begin
            n_fail++;
            $display("FAIL midrst_rx_valid: got %0d pulses required 0", rxv_cnt - rx0);
        end
        wbuf[0] = 8'($urandom);
        write_xact(SLAVE, 1, "midrst_after");
    endtask

    initial begin
        rst_n   = 1'b0;
        sda_m   = 1'b1;
        scl_m   = 1'b1;
        tx_data = 8'h00;
        test_reset();
        test_write();
        test_mismatch();
        test_read();
        test_multi_read();
        test_back_to_back();
        test_reset_mid();
        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave_byte_fsm.md
Name: i2c_slave_byte_fsm

Overview:
Protocol engine directly downstream of the I2C START/STOP detector.
- Consumes the detector's start/stop pulses and its SCL rising-edge pulse.
- Re-synchronises SDA/SCL with the same 2-flop scheme (so every derived event is cycle-aligned with the detector), which also yields the SCL falling edge.
- Matches the 7-bit slave address, shifts write bytes in, shifts read bytes out, and drives ACK.
- Drives SDA only as an open-drain pull-low enable; the pad/top level owns the tristate.

Parameters:
SLAVE_ADDR, 7'h42, 7-bit address this slave responds to

Ports:
clk  input  1  system clock, ≥10x SCL rate
rst_n  input  1  reset, asynchronous, active-low
sda_in  input  1  raw SDA pad input
scl_in  input  1  raw SCL pad input
start_det  input  1  1-cycle START pulse from the detector
stop_det  input  1  1-cycle STOP pulse from the detector
scl_rise  input  1  1-cycle SCL rising-edge pulse from the detector
tx_data  input  8  byte to transmit; sampled when tx_req is high
sda_oe  output  1  1 = pull SDA low, 0 = release
rx_data  output  8  last received write byte
rx_valid  output  1  1-cycle pulse; rx_data updated
tx_req  output  1  1-cycle pulse; tx_data captured this cycle
addr_hit  output  1  high from address-ACK until STOP/START
rw  output  1  R/W bit of the current matched transaction (1 = read)

Behaviour:
- Reset values: all outputs 0; state IDLE; sync flops 2'b11; shift register 0; bit counter 0.
- Internal sync:
  - sda_s = sda_sync[1], same 2-flop chain as the detector.
  - scl_fall = scl_sync[1] & ~scl_sync[0].
- Event priority per cycle: stop_det > start_det > scl edges.
- stop_det in any state: go to IDLE, sda_oe=0, addr_hit=0.
- start_det in any state (including repeated START): go to ADDR, bit counter cleared, sda_oe=0, addr_hit=0.
- Data sampling and driving:
  - SDA is sampled on scl_rise, shifted MSB first.
  - sda_oe changes only on scl_fall.
- States:
  - IDLE: wait for start_det.
  - ADDR: sample 8 bits on scl_rise. After the 8th, compare bits[7:1] with SLAVE_ADDR.
    - Match: latch rw, go to ADDR_ACK.
    - Mismatch: go to WAIT.
  - ADDR_ACK:
    - Next scl_fall: sda_oe=1, addr_hit=1.
    - On the 9th scl_rise with rw=1: tx_req pulse, shift reg ← tx_data.
    - Following scl_fall:
      - rw=0: sda_oe=0, go to WRITE.
      - rw=1: sda_oe=~tx MSB, go to READ.
  - WRITE: sample 8 bits. On the 8th scl_rise: rx_data ← byte, rx_valid pulse the next cycle, go to WR_ACK.
  - WR_ACK: next scl_fall sda_oe=1; following scl_fall sda_oe=0, go to WRITE. Slave always ACKs.
  - READ:
    - On each scl_fall, drive the next bit: sda_oe = ~bit, MSB first.
    - After the 8th bit's scl_fall, release SDA (sda_oe=0) and go to RD_ACK.
  - RD_ACK: on scl_rise sample master ACK.
    - sda_s=0 (ACK): tx_req pulse, load tx_data, go to READ. The first bit is driven on the next scl_fall.
    - sda_s=1 (NACK): go to WAIT.
  - WAIT: sda_oe=0; ignore SCL until start_det or stop_det.
- Bit counter: 3 bits; wraps 7→0 at each byte boundary.
- Latency:
  - sda_oe update: same cycle scl_fall is detected, i.e. 2 clk after the pad edge.
  - rx_valid: 1 clk after the 8th scl_rise.
- Clock stretching: not supported.
- Reset mid-operation: immediate return to reset values; sda_oe releases asynchronously.

Decomposition:
- Shared package i2c_pkg:
  - State encoding constants (IDLE, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, WAIT).
  - Sync reset value 2'b11.
  - Byte width constant 8.
- One natural sub-module, i2c_shift_reg:
  - 8-bit shift register with parallel load (tx) and serial in/out (rx), plus a 3-bit counter and byte_done flag.
  - The FSM instantiates it.

Test Plan:
1. Write: START, 0x84, 0xA5, STOP → sda_oe=1 during both 9th clocks; rx_data=0xA5; exactly one rx_valid pulse; addr_hit falls on STOP.
2. Address mismatch: START, 0x86 (addr 0x43), 0xFF, STOP → sda_oe never 1; rx_valid never pulses; state goes WAIT then IDLE.
3. Read: START, 0x85, tx_data=0x3C, master NACK → one tx_req; bits sampled on SCL high = 0,0,1,1,1,1,0,0; SDA released at ACK slot; state WAIT.
4. Multi-byte read: START, 0x85, tx_data 0x01 then 0x80, master ACKs the first byte and NACKs the second → two tx_req pulses; bytes 0x01 then 0x80 on the bus.
5. Repeated START: START, 0x84, 0x11, START, 0x85, NACK → rx_data=0x11; rw=1 after the second address; no STOP needed.
6. Reset mid-byte (rst_n low during bit 4 of a write) → all outputs 0 immediately; no rx_valid; the next full transaction works.
